// File: rtl/apb_ram_ws.sv
// rtl/apb_ram_ws.sv - parametrised APB4 slave RAM with byte strobes and wait states
//
// Purpose:
//   Word-organised scratch RAM behind an APB slave port. Byte addresses are
//   decoded to word indices. An access is flagged as an error if it is
//   misaligned or if it falls outside DEPTH. Writes honour pstrb. pready can
//   be delayed by WAIT_STATES access cycles. If psel drops while the slave is
//   waiting, the transfer is abandoned and the memory is not touched.
//
// Ports:
//   pclk     in   clock, rising edge
//   preset   in   synchronous active-high reset (also clears the memory)
//   psel     in   slave select
//   penable  in   access-phase indicator
//   pwrite   in   1 = write, 0 = read
//   paddr    in   byte address [ADDR_W]
//   pwdata   in   write data [DATA_W]
//   pstrb    in   write byte strobes [DATA_W/8], ignored on reads
//   prdata   out  registered read data, held until the next read completes
//   pready   out  registered, high for exactly one cycle per transfer
//   pslverr  out  registered error flag, meaningful while pready=1

module apb_ram_ws #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr
);

  localparam int NB     = DATA_W / 8;
  localparam int LSB    = $clog2(NB);
  localparam int IDX_W  = ADDR_W - LSB;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic [NB-1:0]     r_strb;
  logic [DATA_W-1:0] r_prdata;
  logic              r_ready;
  logic              r_slverr;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_setup;
  logic              w_exec;
  logic              w_in_idle;
  logic [ADDR_W-1:0] w_op_addr;
  logic              w_op_write;
  logic [DATA_W-1:0] w_op_wdata;
  logic [NB-1:0]     w_op_strb;
  logic [IDX_W-1:0]  w_idx;
  logic [MEM_AW-1:0] w_widx;
  logic              w_misalign;
  logic              w_oob;
  logic              w_err;

  assign w_setup   = psel & ~penable;
  assign w_in_idle = (r_state == S_IDLE);

  // With zero wait states the operation completes on the same edge that
  // captures the setup phase. At that point the latches are not yet loaded,
  // so the operands come straight from the bus in IDLE. Otherwise they come
  // from the latched copy.
  assign w_op_addr  = w_in_idle ? paddr  : r_addr;
  assign w_op_write = w_in_idle ? pwrite : r_write;
  assign w_op_wdata = w_in_idle ? pwdata : r_wdata;
  assign w_op_strb  = w_in_idle ? pstrb  : r_strb;

  assign w_idx  = w_op_addr[ADDR_W-1:LSB];
  assign w_widx = w_idx[MEM_AW-1:0];

  generate
    if (LSB > 0) begin : g_align
      assign w_misalign = |w_op_addr[LSB-1:0];
    end else begin : g_noalign
      assign w_misalign = 1'b0;
    end
  endgenerate

  assign w_oob = ({1'b0, w_idx} >= DEPTH_C);
  assign w_err = w_misalign | w_oob;

  assign w_exec = (w_in_idle && w_setup && (WAIT_STATES == 0)) ||
                  ((r_state == S_WAIT) && psel && penable && (r_cnt == 4'd1));

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_addr   <= '0;
      r_write  <= 1'b0;
      r_wdata  <= '0;
      r_strb   <= '0;
      r_prdata <= '0;
      r_ready  <= 1'b0;
      r_slverr <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready  <= 1'b0;
          r_slverr <= 1'b0;
          if (w_setup) begin
            r_addr  <= paddr;
            r_write <= pwrite;
            r_wdata <= pwdata;
            r_strb  <= pstrb;
            if (WAIT_STATES != 0) begin
              r_cnt   <= WAIT_STATES[3:0];
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // If psel drops, the transfer is abandoned. If psel stays high
          // without penable, the bus is in an illegal state, so the counter
          // holds until the access phase begins.
          if (!psel) begin
            r_state <= S_IDLE;
          end else if (penable) begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          r_ready  <= 1'b0;
          r_slverr <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // This block comes after the case statement, so when both assign the
      // same register, these assignments take effect.
      if (w_exec) begin
        r_ready  <= 1'b1;
        r_slverr <= w_err;
        r_state  <= S_DONE;
        if (w_op_write) begin
          if (!w_err) begin
            for (int b = 0; b < NB; b++) begin
              if (w_op_strb[b]) begin
                r_mem[w_widx][8*b +: 8] <= w_op_wdata[8*b +: 8];
              end
            end
          end
        end else begin
          r_prdata <= w_err ? '0 : r_mem[w_widx];
        end
      end
    end
  end

  assign prdata  = r_prdata;
  assign pready  = r_ready;
  assign pslverr = r_slverr;

endmodule
